// File: rtl/mmt_sync_pkg.sv
// Shared types and sizing helpers for the mmt_sync req/ack handshake blocks.
package mmt_sync_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } req_tx_state_e;

    localparam int unsigned TMO_CYCLES_DEF = 256;
    localparam int unsigned TMO_CNT_W_DEF  = $clog2(TMO_CYCLES_DEF + 1);

    // A disabled timeout (0 cycles) still needs a one-bit counter to elaborate.
    function automatic int unsigned tmo_cnt_w(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/mmt_sync_single.sv
// Single-bit multi-flop synchroniser; the reset value is 1 only for the async-set variant.
module mmt_sync_single #(
    parameter int Depth      = 2,
    parameter bit AsyncReset = 1'b1,
    parameter bit AsyncSet   = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    localparam logic [Depth-1:0] RstVal = {Depth{AsyncSet}};

    logic [Depth-1:0] stages;

    generate
        if (AsyncReset || AsyncSet) begin : g_async
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) stages <= RstVal;
                else       stages <= {stages[Depth-2:0], d};
            end
        end else begin : g_sync
            always_ff @(posedge clk) begin
                if (!rstn) stages <= RstVal;
                else       stages <= {stages[Depth-2:0], d};
            end
        end
    endgenerate

    assign q = stages[Depth-1];

endmodule

// File: rtl/mmt_sync_req_tx.sv
// Source side of the 4-phase req/ack CDC handshake: buffers event pulses and
// runs one full req/ack cycle per event, with sticky overflow/timeout flags.
module mmt_sync_req_tx
    import mmt_sync_pkg::*;
#(
    parameter int Depth         = 2,
    parameter int CntW          = 4,
    parameter int TimeoutCycles = 256
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            evt_i,
    input  logic            ack_i,
    input  logic            clr_i,
    output logic            req_o,
    output logic            done_o,
    output logic            busy_o,
    output logic [CntW-1:0] pend_cnt_o,
    output logic            err_ovf_o,
    output logic            err_tmo_o
);

    localparam int              TmoW    = tmo_cnt_w(TimeoutCycles);
    localparam bit              TmoEn   = (TimeoutCycles != 0);
    localparam logic [TmoW-1:0] TmoMax  = TmoW'(TimeoutCycles);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] CntMax  = '1;

    req_tx_state_e   state;
    req_tx_state_e   state_nxt;
    logic            ack_s;
    logic            launch;
    logic            waiting;
    logic            state_chg;
    logic            ovf_hit;
    logic            tmo_hit;
    logic [TmoW-1:0] tmo_cnt;

    mmt_sync_single #(
        .Depth      (Depth),
        .AsyncReset (1'b1),
        .AsyncSet   (1'b0)
    ) u_ack_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (ack_i),
        .q    (ack_s)
    );

    // A new request only starts once the destination has released its ack.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if ((pend_cnt_o != '0) && !ack_s) begin
                    state_nxt = REQ_HI;
                    launch    = 1'b1;
                end
            end
            REQ_HI:  if (ack_s)  state_nxt = REQ_LO;
            REQ_LO:  if (!ack_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign waiting   = (state != IDLE);
    assign state_chg = (state_nxt != state);
    assign ovf_hit   = evt_i && !launch && (pend_cnt_o == CntMax);
    assign tmo_hit   = TmoEn && waiting && !state_chg && (tmo_cnt == TmoLast);
    assign busy_o    = waiting || (pend_cnt_o != '0);

    // req_o is taken from the next state so it moves together with the state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            req_o  <= 1'b0;
            done_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            req_o  <= (state_nxt == REQ_HI);
            done_o <= (state == REQ_LO) && (state_nxt == IDLE);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_cnt_o <= '0;
        end else if (evt_i && !launch && (pend_cnt_o != CntMax)) begin
            pend_cnt_o <= pend_cnt_o + CntW'(1);
        end else if (launch && !evt_i) begin
            pend_cnt_o <= pend_cnt_o - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt <= '0;
        end else if (state_chg) begin
            tmo_cnt <= '0;
        end else if (TmoEn && waiting && (tmo_cnt != TmoMax)) begin
            tmo_cnt <= tmo_cnt + TmoW'(1);
        end
    end

    // A fresh error in the same cycle as clr_i keeps the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_ovf_o <= 1'b0;
            err_tmo_o <= 1'b0;
        end else begin
            err_ovf_o <= ovf_hit || (err_ovf_o && !clr_i);
            err_tmo_o <= tmo_hit || (err_tmo_o && !clr_i);
        end
    end

endmodule

// File: tb/tb_mmt_sync_req_tx.sv
// Directed bench: dut_a runs in loopback with defaults, dut_b uses CntW=2 and a
// 16-cycle timeout with a hand-driven ack.
module tb_mmt_sync_req_tx;

    localparam int Depth = 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic       clr;
    logic       evt_a, evt_b, ack_b;
    logic       req_a, done_a, busy_a, ovf_a, tmo_a;
    logic       req_b, done_b, busy_b, ovf_b, tmo_b;
    logic [3:0] pend_a;
    logic [1:0] pend_b;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mmt_sync_req_tx #(.Depth(Depth), .CntW(4), .TimeoutCycles(256)) dut_a (
        .clk        (clk),
        .rstn       (rstn),
        .evt_i      (evt_a),
        .ack_i      (req_a),
        .clr_i      (clr),
        .req_o      (req_a),
        .done_o     (done_a),
        .busy_o     (busy_a),
        .pend_cnt_o (pend_a),
        .err_ovf_o  (ovf_a),
        .err_tmo_o  (tmo_a)
    );

    mmt_sync_req_tx #(.Depth(Depth), .CntW(2), .TimeoutCycles(16)) dut_b (
        .clk        (clk),
        .rstn       (rstn),
        .evt_i      (evt_b),
        .ack_i      (ack_b),
        .clr_i      (clr),
        .req_o      (req_b),
        .done_o     (done_b),
        .busy_o     (busy_b),
        .pend_cnt_o (pend_b),
        .err_ovf_o  (ovf_b),
        .err_tmo_o  (tmo_b)
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock edge, then settle 1 ns so inputs and samples sit away from the edge.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int first_done;
        int last_done;
        int n_done;
        int peak;
        logic spacing_ok;
        logic saw_done;

        rstn  = 1'b0;
        clr   = 1'b0;
        evt_a = 1'b0;
        evt_b = 1'b0;
        ack_b = 1'b0;

        #2;
        checkOutput("rst_req_a",  8'(req_a),  8'h0);
        checkOutput("rst_busy_a", 8'(busy_a), 8'h0);
        checkOutput("rst_pend_a", 8'(pend_a), 8'h0);
        checkOutput("rst_done_a", 8'(done_a), 8'h0);
        checkOutput("rst_errs_b", 8'({ovf_b, tmo_b}), 8'h0);
        checkOutput("rst_req_b",  8'(req_b),  8'h0);

        applyStimulus(2);
        rstn = 1'b1;
        applyStimulus(2);

        $display("[TB] single event in loopback");
        evt_a = 1'b1;
        applyStimulus(1);
        evt_a = 1'b0;
        checkOutput("c1_pend_e0", 8'(pend_a), 8'h1);
        checkOutput("c1_req_e0",  8'(req_a),  8'h0);
        applyStimulus(1);
        checkOutput("c1_req_e1",  8'(req_a),  8'h1);
        checkOutput("c1_pend_e1", 8'(pend_a), 8'h0);
        applyStimulus(2);
        checkOutput("c1_req_e3",  8'(req_a),  8'h1);
        applyStimulus(1);
        checkOutput("c1_req_e4",  8'(req_a),  8'h0);
        applyStimulus(2);
        checkOutput("c1_done_e6", 8'(done_a), 8'h0);
        applyStimulus(1);
        checkOutput("c1_done_e7", 8'(done_a), 8'h1);
        applyStimulus(1);
        checkOutput("c1_done_e8", 8'(done_a), 8'h0);
        checkOutput("c1_busy_e8", 8'(busy_a), 8'h0);

        $display("[TB] five back-to-back events in loopback");
        first_done = -1;
        last_done  = -1;
        n_done     = 0;
        peak       = 0;
        spacing_ok = 1'b1;
        evt_a = 1'b1;
        for (int e = 0; e < 45; e++) begin
            applyStimulus(1);
            if (e == 4) evt_a = 1'b0;
            if (int'(pend_a) > peak) peak = int'(pend_a);
            if (done_a) begin
                if (first_done < 0) first_done = e;
                else if (e - last_done != 7) spacing_ok = 1'b0;
                last_done = e;
                n_done++;
            end
        end
        checkOutput("c2_peak",       8'(peak),       8'h4);
        checkOutput("c2_first_done", 8'(first_done), 8'h7);
        checkOutput("c2_n_done",     8'(n_done),     8'h5);
        checkOutput("c2_spacing",    8'(spacing_ok), 8'h1);
        checkOutput("c2_ovf",        8'(ovf_a),      8'h0);
        checkOutput("c2_busy_end",   8'(busy_a),     8'h0);

        $display("[TB] saturation and timeout with ack held low");
        evt_b = 1'b1;
        applyStimulus(2);
        checkOutput("c3_req_e1",  8'(req_b),  8'h1);
        checkOutput("c3_pend_e1", 8'(pend_b), 8'h1);
        applyStimulus(2);
        checkOutput("c3_pend_e3", 8'(pend_b), 8'h3);
        checkOutput("c3_ovf_e3",  8'(ovf_b),  8'h0);
        applyStimulus(1);
        evt_b = 1'b0;
        checkOutput("c3_pend_e4", 8'(pend_b), 8'h3);
        checkOutput("c3_ovf_e4",  8'(ovf_b),  8'h1);
        applyStimulus(12);
        checkOutput("c3_tmo_e16", 8'(tmo_b),  8'h0);
        applyStimulus(1);
        checkOutput("c3_tmo_e17", 8'(tmo_b),  8'h1);
        checkOutput("c3_req_e17", 8'(req_b),  8'h1);

        $display("[TB] clear flags, then finish handshakes by hand");
        clr = 1'b1;
        applyStimulus(1);
        clr = 1'b0;
        checkOutput("c4_flags_clr", 8'({ovf_b, tmo_b}), 8'h0);
        ack_b = 1'b1;
        applyStimulus(2);
        checkOutput("c4_req_m2", 8'(req_b), 8'h1);
        applyStimulus(1);
        checkOutput("c4_req_m3", 8'(req_b), 8'h0);
        ack_b = 1'b0;
        applyStimulus(3);
        checkOutput("c4_done_n3", 8'(done_b), 8'h1);
        checkOutput("c4_pend_n3", 8'(pend_b), 8'h3);
        applyStimulus(1);
        checkOutput("c4_req_n4",  8'(req_b),  8'h1);
        checkOutput("c4_pend_n4", 8'(pend_b), 8'h2);
        checkOutput("c4_done_n4", 8'(done_b), 8'h0);

        $display("[TB] ack still high while idle blocks the next launch");
        ack_b = 1'b1;
        applyStimulus(3);
        checkOutput("c5_req_p3", 8'(req_b), 8'h0);
        ack_b = 1'b0;
        applyStimulus(1);
        ack_b = 1'b1;
        applyStimulus(2);
        checkOutput("c5_done_q3", 8'(done_b), 8'h1);
        applyStimulus(3);
        checkOutput("c5_req_q6",  8'(req_b),  8'h0);
        checkOutput("c5_pend_q6", 8'(pend_b), 8'h2);
        checkOutput("c5_busy_q6", 8'(busy_b), 8'h1);
        ack_b = 1'b0;
        applyStimulus(Depth);
        checkOutput("c5_req_r2",  8'(req_b),  8'h0);
        applyStimulus(1);
        checkOutput("c5_req_r3",  8'(req_b),  8'h1);
        checkOutput("c5_pend_r3", 8'(pend_b), 8'h1);

        $display("[TB] asynchronous reset mid-handshake");
        evt_b = 1'b1;
        applyStimulus(2);
        evt_b = 1'b0;
        checkOutput("c6_pend_pre", 8'(pend_b), 8'h3);
        checkOutput("c6_req_pre",  8'(req_b),  8'h1);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("c6_req_rst",  8'(req_b),  8'h0);
        checkOutput("c6_pend_rst", 8'(pend_b), 8'h0);
        checkOutput("c6_busy_rst", 8'(busy_b), 8'h0);
        applyStimulus(2);
        rstn = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1);
            if (done_b || req_b) saw_done = 1'b1;
        end
        checkOutput("c6_quiet_after_rst", 8'(saw_done), 8'h0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mmt_sync_req_tx.md
Name: mmt_sync_req_tx

Overview:
Source-side endpoint of the 4-phase req/ack CDC handshake whose destination side samples req through mmt_sync_single.
- Turns single-cycle event pulses in the local clock domain into one full req/ack handshake per event.
- Buffers pending events in a saturating counter.
- Resynchronises the returning ack_i internally.
- Flags overflow and handshake timeout as sticky errors.

Parameters:
Depth, 2, flop stages on the ack_i synchroniser; legal range 2..4.
CntW, 4, pending-event counter width; max pending = 2**CntW-1.
TimeoutCycles, 256, cycles allowed in one waiting state before timeout flag; 0 disables timeout.

Ports:
clk  input  1  single clock; all logic on rising edge.
rstn  input  1  asynchronous active-low reset.
evt_i  input  1  event request pulse; each high cycle counts as one event.
ack_i  input  1  ack level from the destination domain; asynchronous to clk.
clr_i  input  1  clears err_ovf_o and err_tmo_o.
req_o  output  1  req level to the destination domain; driven directly from a flop, no logic after it.
done_o  output  1  one-cycle pulse when a handshake completes.
busy_o  output  1  high when the FSM is not IDLE or pend_cnt_o != 0.
pend_cnt_o  output  CntW  events accepted but not yet launched.
err_ovf_o  output  1  sticky; an event was lost to counter saturation.
err_tmo_o  output  1  sticky; a handshake phase exceeded TimeoutCycles.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; internal counters 0; synchroniser flops 0.
- ack_s is ack_i through an mmt_sync_single instance (Depth, AsyncReset=1, AsyncSet=0). Latency is Depth edges.
- FSM states:
  - IDLE (req_o=0): if pend_cnt!=0 and ack_s==0, go to REQ_HI and decrement pend_cnt. If ack_s==1, stay in IDLE; the destination has not yet released.
  - REQ_HI (req_o=1): on ack_s==1, go to REQ_LO.
  - REQ_LO (req_o=0): on ack_s==0, go to IDLE and assert done_o on the following cycle.
- req_o is registered from the next-state value, so it changes in the same cycle as the state.
- pend_cnt update:
  - +1 on evt_i; -1 on launch.
  - evt_i and launch in the same cycle: count unchanged.
  - Saturates at max. evt_i while at max with no launch in that cycle: count unchanged and err_ovf_o set.
- Event-to-request latency: evt_i sampled at edge k sets pend_cnt=1 after edge k. Launch happens at edge k+1, so req_o=1 after edge k+1. There is no bypass path.
- Minimum launch-to-launch spacing: 2*Depth+3 cycles.
- Timeout counter:
  - Zeroed on every state change; counts while in REQ_HI or REQ_LO.
  - On reaching TimeoutCycles: err_tmo_o set and the counter holds.
  - The FSM keeps waiting. The handshake is never abandoned, so req_o is never withdrawn early.
- clr_i clears both error flags. If clr_i coincides with a new error event in the same cycle, the flag is set (set wins).
- Reset mid-handshake: req_o drops to 0 asynchronously; pending events are discarded.

Decomposition:
- Shared package mmt_sync_pkg:
  - enum req_tx_state_e {IDLE, REQ_HI, REQ_LO}.
  - Localparam for timeout counter width, $clog2(TimeoutCycles+1).
- One sub-module: the existing mmt_sync_single, instantiated for the ack_i path. No other hierarchy.

Test Plan:
- Loopback (ack_i=req_o), Depth=2; evt_i pulse at edge 0 → req_o high after edge 1, low after edge 4; done_o high for exactly one cycle after edge 7; pend_cnt_o returns to 0 after edge 1.
- Loopback; evt_i held high 5 consecutive cycles → pend_cnt_o peaks at 4; exactly 5 done_o pulses spaced 7 cycles apart; err_ovf_o stays 0.
- CntW=2, ack_i tied 0; 5 evt_i pulses → pend_cnt_o saturates at 3; err_ovf_o=1; after TimeoutCycles=16 cycles in REQ_HI, err_tmo_o=1 and req_o stays 1.
- After the previous case: clr_i pulse → both flags 0; then ack_i=1 → FSM reaches REQ_LO; ack_i=0 → done_o pulse; remaining pending events launch in order.
- ack_i forced 1 while IDLE with pend_cnt_o=2 → no launch while ack_s=1; launch occurs Depth+1 edges after ack_i falls.
- rstn asserted while in REQ_HI with pend_cnt_o=3 → req_o, pend_cnt_o, and busy_o read 0 immediately, without waiting for a clock edge; no done_o after release.
